// File: rtl/banco_pkg.sv
// Shared constants and types for the parametrised MIPS register file.
// Default geometry, clear-sequencer state encoding and the hardwired-zero address.
package banco_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_RD   = 2;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/banco_registros_param_rd_port.sv
// One registered read port of the register file.
// Same-edge writes to the addressed register are bypassed and report not-pending.
module banco_rd_port
  import banco_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_acc,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_pend,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_pending
);

  logic              w_bypass;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_pending;

  assign w_bypass = i_wr_acc && (i_wr_addr == i_rd_addr) &&
                    (i_rd_addr != ADDR_W'(REG_ZERO));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data    <= '0;
      r_rd_pending <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_data    <= w_bypass ? i_wr_data : i_mem_data;
      r_rd_pending <= w_bypass ? 1'b0 : i_pend;
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_rd_pending = r_rd_pending;

endmodule

// File: rtl/banco_registros_param.sv
// General-purpose register file: N_RD registered read ports, pending-write
// scoreboard, multi-cycle clear sweep and a combinational debug read port.
//
// state    | meaning
// ST_IDLE  | normal operation; writes, reservations and clear requests accepted
// ST_CLEAR | sweeping mem[1..DEPTH-1] to zero, one register per cycle; busy=1
module banco_registros_param
  import banco_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = DEF_N_RD
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_RD-1:0]          i_rd_en,
  input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [N_RD*DATA_W-1:0]   o_rd_data,
  output logic [N_RD-1:0]          o_rd_pending,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  input  logic                     i_clr_req,
  output logic                     o_busy,
  input  logic [ADDR_W-1:0]        i_dbg_addr,
  output logic [DATA_W-1:0]        o_dbg_data
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W-1:0] r_ptr;
  logic              w_idle;
  logic              w_clearing;
  logic              w_wr_acc;
  logic              w_rsv_acc;
  logic              w_clr_start;
  logic              w_sweep_last;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_clearing   = (r_state == ST_CLEAR);
  assign w_wr_acc     = w_idle && i_wr_en && (i_wr_addr != ZERO_A);
  assign w_rsv_acc    = w_idle && i_rsv_en && (i_rsv_addr != ZERO_A);
  assign w_clr_start  = w_idle && i_clr_req;
  assign w_sweep_last = w_clearing && (r_ptr == LAST_A);
  assign o_busy       = w_clearing;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_clr_req)    w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_sweep_last) w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)          r_ptr <= FIRST_A;
    else if (w_clr_start)  r_ptr <= FIRST_A;
    else if (w_clearing)   r_ptr <= w_sweep_last ? FIRST_A : r_ptr + FIRST_A;
  end

  // Entry 0 is reset and never written, so it doubles as the zero register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_acc) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end else if (w_clearing) begin
      r_mem[r_ptr] <= '0;
    end
  end

  // Reservation is applied after the write so a same-cycle new producer wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend <= '0;
    end else if (w_clr_start) begin
      r_pend <= '0;
    end else begin
      if (w_wr_acc)  r_pend[i_wr_addr]  <= 1'b0;
      if (w_rsv_acc) r_pend[i_rsv_addr] <= 1'b1;
    end
  end

  assign o_dbg_data = (i_dbg_addr == ZERO_A) ? '0 : r_mem[i_dbg_addr];

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = i_rd_addr[p*ADDR_W +: ADDR_W];

    banco_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_rd_en      (i_rd_en[p]),
      .i_rd_addr    (w_addr),
      .i_wr_acc     (w_wr_acc),
      .i_wr_addr    (i_wr_addr),
      .i_wr_data    (i_wr_data),
      .i_mem_data   (r_mem[w_addr]),
      .i_pend       (r_pend[w_addr]),
      .o_rd_data    (o_rd_data[p*DATA_W +: DATA_W]),
      .o_rd_pending (o_rd_pending[p])
    );
  end

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed self-checking bench for banco_registros_param: default geometry
// plus a small 3-port, 16-bit, 8-entry instance.
module tb_banco_registros_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        clr_req;
  logic        busy;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [2:0]  p3_rd_en;
  logic [8:0]  p3_rd_addr;
  logic [47:0] p3_rd_data;
  logic [2:0]  p3_rd_pending;
  logic        p3_wr_en;
  logic [2:0]  p3_wr_addr;
  logic [15:0] p3_wr_data;
  logic        p3_rsv_en;
  logic [2:0]  p3_rsv_addr;
  logic        p3_clr_req;
  logic        p3_busy;
  logic [2:0]  p3_dbg_addr;
  logic [15:0] p3_dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  banco_registros_param #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_pending(rd_pending),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .i_clr_req(clr_req), .o_busy(busy),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  banco_registros_param #(.DATA_W(16), .ADDR_W(3), .N_RD(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_en(p3_rd_en), .i_rd_addr(p3_rd_addr), .o_rd_data(p3_rd_data),
    .o_rd_pending(p3_rd_pending),
    .i_wr_en(p3_wr_en), .i_wr_addr(p3_wr_addr), .i_wr_data(p3_wr_data),
    .i_rsv_en(p3_rsv_en), .i_rsv_addr(p3_rsv_addr), .i_clr_req(p3_clr_req), .o_busy(p3_busy),
    .i_dbg_addr(p3_dbg_addr), .o_dbg_data(p3_dbg_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a0, input logic [4:0] a1);
    rd_en = 2'b11; rd_addr = {a1, a0};
    step();
    rd_en = 2'b00;
  endtask

  initial begin : main
    int cnt;
    int bad;
    rst_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0; dbg_addr = 5'd5;
    p3_rd_en = '0; p3_rd_addr = '0; p3_wr_en = 1'b0; p3_wr_addr = '0; p3_wr_data = '0;
    p3_rsv_en = 1'b0; p3_rsv_addr = '0; p3_clr_req = 1'b0; p3_dbg_addr = '0;
    step(); step();
    check("rst_rd_data", rd_data, 64'h0);
    check("rst_rd_pending", 64'(rd_pending), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_dbg", 64'(dbg_data), 64'h0);
    check("rst_busy3", 64'(p3_busy), 64'h0);
    rst_n = 1'b1;

    // Basic write/read, including the hardwired zero register
    do_write(5'd8, 32'hDEADBEEF);
    dbg_addr = 5'd8; #1;
    check("dbg_after_write", 64'(dbg_data), 64'hDEADBEEF);
    do_read(5'd8, 5'd0);
    check("rd_r8", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("rd_r8_pend", 64'(rd_pending[0]), 64'h0);
    do_write(5'd0, 32'h1234);
    do_read(5'd0, 5'd0);
    check("rd_r0", rd_data, 64'h0);
    dbg_addr = 5'd0; #1;
    check("dbg_r0", 64'(dbg_data), 64'h0);

    // Write-first bypass on port 1 while port 0 reads an older value
    do_write(5'd10, 32'd7);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    do_read(5'd10, 5'd9);
    wr_en = 1'b0;
    check("bypass_p1", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    check("plain_p0_r10", 64'(rd_data[31:0]), 64'd7);
    rd_en = 2'b00; rd_addr = {5'd8, 5'd8};
    step();
    check("hold_when_disabled", rd_data, {32'hA5A5A5A5, 32'd7});

    // Scoreboard
    rsv_en = 1'b1; rsv_addr = 5'd12;
    step();
    rsv_en = 1'b0;
    do_read(5'd12, 5'd0);
    check("rsv_visible_next", 64'(rd_pending[0]), 64'h1);
    rsv_en = 1'b1; rsv_addr = 5'd13;
    do_read(5'd13, 5'd0);
    rsv_en = 1'b0;
    check("rsv_same_cycle_hidden", 64'(rd_pending[0]), 64'h0);
    do_read(5'd13, 5'd0);
    check("rsv_r13_next", 64'(rd_pending[0]), 64'h1);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'd5;
    do_read(5'd12, 5'd0);
    wr_en = 1'b0;
    check("wr_clears_pend_data", 64'(rd_data[31:0]), 64'd5);
    check("wr_clears_pend_flag", 64'(rd_pending[0]), 64'h0);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'd9; rsv_en = 1'b1; rsv_addr = 5'd12;
    do_read(5'd0, 5'd12);
    wr_en = 1'b0; rsv_en = 1'b0;
    check("rsv_wr_bypass_pend", 64'(rd_pending[1]), 64'h0);
    do_read(5'd12, 5'd0);
    check("rsv_wins_pend", 64'(rd_pending[0]), 64'h1);
    check("rsv_wins_data", 64'(rd_data[31:0]), 64'd9);

    // Clear sweep over a filled array
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    rsv_en = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    dbg_addr = 5'd31; #1;
    check("clr_r31_not_yet", 64'(dbg_data), 64'd31);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      step();
    end
    wr_en = 1'b0;
    check("clr_busy_cycles", 64'(cnt), 64'd31);
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      if (dbg_data != 32'h0) bad++;
    end
    check("clr_dbg_all_zero", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      do_read(5'(i), 5'(i));
      if (rd_data != 64'h0 || rd_pending != 2'b00) bad++;
    end
    check("clr_ports_zero_nopend", 64'(bad), 64'd0);
    do_write(5'd5, 32'h55);
    dbg_addr = 5'd5; #1;
    check("write_after_clr", 64'(dbg_data), 64'h55);

    // Reset in the middle of a sweep
    do_write(5'd20, 32'h2020);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (8) step();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd20};
    step();
    check("mid_clr_read_r20", 64'(rd_data[31:0]), 64'h2020);
    check("mid_clr_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    step();
    rd_en = 2'b00;
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_rd_data", rd_data, 64'h0);
    dbg_addr = 5'd20; #1;
    check("rst_mid_r20", 64'(dbg_data), 64'h0);
    rst_n = 1'b1;
    do_write(5'd20, 32'h77);
    check("wr_after_rst", 64'(dbg_data), 64'h77);

    // Three-port narrow instance
    p3_wr_en = 1'b1;
    p3_wr_addr = 3'd1; p3_wr_data = 16'h1111; step();
    p3_wr_addr = 3'd2; p3_wr_data = 16'h2222; step();
    p3_wr_addr = 3'd7; p3_wr_data = 16'h7777; step();
    p3_wr_en = 1'b0;
    p3_rd_en = 3'b111; p3_rd_addr = {3'd7, 3'd2, 3'd1};
    step();
    p3_rd_en = 3'b000;
    check("p3_port0_r1", 64'(p3_rd_data[15:0]), 64'h1111);
    check("p3_port1_r2", 64'(p3_rd_data[31:16]), 64'h2222);
    check("p3_port2_r7", 64'(p3_rd_data[47:32]), 64'h7777);
    p3_clr_req = 1'b1;
    step();
    p3_clr_req = 1'b0;
    cnt = 0;
    while (p3_busy && cnt < 100) begin
      cnt++;
      step();
    end
    check("p3_clr_cycles", 64'(cnt), 64'd7);
    p3_dbg_addr = 3'd7; #1;
    check("p3_r7_cleared", 64'(p3_dbg_data), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/banco_registros_param.md
# banco_registros_param

Parametrised, fully synchronous general-purpose register file for the single-cycle/pipelined MIPS datapath. It provides N_RD registered read ports with write-first bypass and register 0 hardwired to zero. It adds a per-register pending-write scoreboard for hazard detection, a multi-cycle clear sequencer, and a single debug read port that replaces the 31 per-register observation buses.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- N_RD, 2, number of read ports (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_en  in  N_RD  per-port read enable
- rd_addr  in  N_RD*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_pending  out  N_RD  registered: read register has an outstanding reservation
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve (mark pending) request
- rsv_addr  in  ADDR_W  register to reserve
- clr_req  in  1  start clear sweep (single-cycle pulse sufficient)
- busy  out  1  clear sweep in progress
- dbg_addr  in  ADDR_W  debug address
- dbg_data  out  DATA_W  combinational mem[dbg_addr]; 0 for address 0

## Operation

- Storage: mem[1..DEPTH-1]. Address 0 always reads 0. Writes and reservations to 0 are ignored.
- Write: when wr_en=1, state IDLE, and wr_addr≠0, mem[wr_addr] takes wr_data at the edge and pend[wr_addr] is cleared.
- Reserve: when rsv_en=1, state IDLE, and rsv_addr≠0, pend[rsv_addr] is set. If a reserve and a write target the same address in one cycle, pending ends set (reserve wins: new producer).
- Read, per port p, when rd_en[p]=1:
  - rd_data[p] ← wr_data if the write is accepted this cycle and wr_addr==rd_addr[p]≠0, else mem[rd_addr[p]].
  - rd_pending[p] ← 0 if the same bypass condition holds, else pend[rd_addr[p]].
  - A reservation made in the same cycle is not visible.
- When rd_en[p]=0, rd_data[p] and rd_pending[p] hold their values.
- FSM states are IDLE and CLEAR.
  - IDLE→CLEAR when clr_req=1. At that edge all pend bits are cleared and ptr←1.
  - In CLEAR, each cycle sets mem[ptr]←0 and ptr←ptr+1. When ptr==DEPTH-1, that register is cleared and the FSM returns to IDLE.
  - busy=1 exactly while the state is CLEAR.
- During CLEAR, wr_en, rsv_en and clr_req are ignored, with no queuing. Reads remain legal and return the current array content (partially cleared).
- Reset, rst_n=0 at an edge:
  - All mem, pend, rd_data and rd_pending go to 0; busy=0; state IDLE; ptr=1.
  - Reset overrides every other input, including mid-sweep.

## Timing

- Read latency is 1 cycle: the address presented at edge k appears on rd_data after edge k. Same-edge write data is bypassed, with no stale read.
- A write is visible on dbg_data immediately after its edge.
- Clear: clr_req sampled at edge k, then busy=1 from edge k through edge k+DEPTH-1, for DEPTH-1 cycles (31 at default). The first accepted write is at edge k+DEPTH.
- Reserve at edge k: a read issued at edge k+1 reports pending=1.
- Reset values: rd_data=0, rd_pending=0, busy=0. dbg_data follows mem, so it reads 0.

## Structure

- Package banco_pkg:
  - default DATA_W/ADDR_W/N_RD localparams
  - state enum {ST_IDLE, ST_CLEAR}
  - REG_ZERO=0 address constant
- Sub-module banco_rd_port: one read port (address compare, bypass mux, output/pending registers). It is instantiated N_RD times by a generate loop.
- Top level holds the array, pending vector, clear FSM/ptr and debug mux.

## Test plan

- Write/read: write 0xDEADBEEF to r8; read r8 on port 0 next cycle → rd_data[0]=0xDEADBEEF, rd_pending[0]=0. Write 0x1234 to r0, read r0 → 0.
- Bypass: same cycle wr_en r9=0xA5A5A5A5 and port 1 reads r9 → after the edge rd_data[1]=0xA5A5A5A5. Port 0 reads r10 (holds 7) → 7.
- Scoreboard: reserve r12; next cycle read r12 → rd_pending=1. Write r12=5 with same-cycle read → data 5, pending 0. Reserve and write r12 in one cycle → later read shows pending=1.
- Clear: fill r1..r31 with index value; pulse clr_req → busy high for 31 cycles. Writes during busy are dropped. Afterwards all registers read 0 and all pending bits are 0.
- Reset mid-clear: assert rst_n=0 at sweep cycle 10 → next cycle busy=0, rd_data=0, and r20 reads 0. After release, a write to r20 is accepted immediately.
- Parametric: N_RD=3, DATA_W=16, ADDR_W=3 → three ports read r1/r2/r7 concurrently with correct values. Clear lasts 7 cycles.
